// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 5-stage pipeline. Takes the EX/MEM register
//   outputs, performs word/half/byte loads and stores against a local data
//   memory, resolves the branch decision, and registers the results into the
//   MEM/WB pipeline register that feeds write-back.
//
// Ports
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Stall               hold MEM/WB and suppress memory writes
//   Flush               load a bubble into MEM/WB control bits
//   MemWrite_in         store enable
//   MemRead_in          load enable
//   Branch_in, Zero_in  branch instruction / ALU zero flag
//   MemtoReg_in         write-back selects load data
//   RegWrite_in         register write enable
//   ALUAddResult_in     branch target
//   ALUResult_in        byte address / ALU result
//   WriteData_in        store data
//   DestReg_in          destination register
//   Store_size_in       00 word, 01 half, 10 byte, 11 no store
//   Load_size_in        00 word, 01 half signed, 10 byte signed, 11 byte unsigned
//   PCSrc, BranchTarget combinational branch decision and target
//   *_out               registered MEM/WB fields
//   Misalign_sticky     set on any misaligned access, cleared only by reset
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int DEPTH     = 1024,
   parameter int ADDR_BITS = 10
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic        Branch_in,
   input  logic        Zero_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   input  logic [31:0] ALUAddResult_in,
   input  logic [31:0] ALUResult_in,
   input  logic [31:0] WriteData_in,
   input  logic [4:0]  DestReg_in,
   input  logic [1:0]  Store_size_in,
   input  logic [1:0]  Load_size_in,
   output logic        PCSrc,
   output logic [31:0] BranchTarget,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic [31:0] ReadData_out,
   output logic [31:0] ALUResult_out,
   output logic [4:0]  DestReg_out,
   output logic        Misalign_out,
   output logic        Misalign_sticky
);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_NONE = 2'b11;   // store: no store; load: byte unsigned

   logic [31:0] mem [DEPTH];

   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]           byte_sel;
   logic [31:0]          rd_word;
   logic [31:0]          st_word;
   logic [31:0]          load_data;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic                 load_mis;
   logic                 store_mis;
   logic                 misalign;
   logic                 store_en;

   // Upper address bits are dropped, so accesses wrap modulo DEPTH words.
   assign word_idx = ALUResult_in[ADDR_BITS+1:2];
   assign byte_sel = ALUResult_in[1:0];
   assign rd_word  = mem[word_idx];

   // Branch resolution is purely combinational and independent of reset.
   assign PCSrc        = Branch_in & Zero_in;
   assign BranchTarget = ALUAddResult_in;

   // Byte accesses (load sizes 10/11, store size 10) are never misaligned;
   // store size 11 is not a store at all.
   assign load_mis  = MemRead_in &
                      (((Load_size_in == SZ_WORD) && (byte_sel != 2'b00)) ||
                       ((Load_size_in == SZ_HALF) && byte_sel[0]));
   assign store_mis = MemWrite_in &
                      (((Store_size_in == SZ_WORD) && (byte_sel != 2'b00)) ||
                       ((Store_size_in == SZ_HALF) && byte_sel[0]));
   assign misalign  = load_mis | store_mis;

   // Rst_n gates the write so a store in flight when reset asserts is dropped.
   assign store_en = MemWrite_in & ~Stall & ~store_mis &
                     (Store_size_in != SZ_NONE) & Rst_n;

   // Merge the new lanes into the current word; untouched lanes keep old data.
   always_comb begin
      st_word = rd_word;
      case (Store_size_in)
         SZ_WORD: st_word = WriteData_in;
         SZ_HALF: begin
            if (byte_sel[1]) st_word[31:16] = WriteData_in[15:0];
            else             st_word[15:0]  = WriteData_in[15:0];
         end
         SZ_BYTE: st_word[{byte_sel, 3'b000} +: 8] = WriteData_in[7:0];
         default: st_word = rd_word;
      endcase
   end

   // Little-endian lane select with sign/zero extension.
   always_comb begin
      ld_byte   = rd_word[{byte_sel, 3'b000} +: 8];
      ld_half   = byte_sel[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = '0;
      if (MemRead_in && !load_mis) begin
         case (Load_size_in)
            SZ_WORD: load_data = rd_word;
            SZ_HALF: load_data = {{16{ld_half[15]}}, ld_half};
            SZ_BYTE: load_data = {{24{ld_byte[7]}}, ld_byte};
            default: load_data = {24'd0, ld_byte};
         endcase
      end
   end

   // NOTE: the data array has no reset; clearing it would turn the RAM into a
   // huge register bank, and software must not rely on power-up contents.
   always_ff @(posedge Clk) begin
      if (store_en) mem[word_idx] <= st_word;
   end

   // MEM/WB pipeline register. Stall holds everything (including the sticky
   // flag); Flush zeroes only the control bits so data fields still advance.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RegWrite_out    <= 1'b0;
         MemtoReg_out    <= 1'b0;
         ReadData_out    <= '0;
         ALUResult_out   <= '0;
         DestReg_out     <= '0;
         Misalign_out    <= 1'b0;
         Misalign_sticky <= 1'b0;
      end else if (!Stall) begin
         RegWrite_out    <= RegWrite_in & ~Flush;
         MemtoReg_out    <= MemtoReg_in & ~Flush;
         Misalign_out    <= misalign & ~Flush;
         ReadData_out    <= load_data;
         ALUResult_out   <= ALUResult_in;
         DestReg_out     <= DestReg_in;
         Misalign_sticky <= Misalign_sticky | misalign;
      end
   end

endmodule
